button_color_select: RTL and testbench



---
 rtl/color_pkg.sv | 19 +
 rtl/debounce.sv | 44 ++++
 rtl/button_color_select.sv | 142 ++++++++++++++
 tb/tb_button_color_select.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared types and constants for the push-button colour selector.
package color_pkg;

    localparam int NUM_COLORS = 6;

    typedef logic [2:0] color_idx_t;

    // Active-low {R,G,B} patterns: red, yellow, green, cyan, blue, magenta.
    localparam logic [2:0] COLOR_RGB_N [0:NUM_COLORS-1] = '{
        3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010
    };

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HELD      = 2'd1,
        LONG_DONE = 2'd2
    } press_state_t;

endpackage

// File: rtl/debounce.sv
// Synchroniser and debounce filter for an active-low asynchronous button.
module debounce #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic in_n,
    output logic level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   pressed_raw;
    logic [CNT_W-1:0]       cnt;

    // Input synchroniser, idles at released
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p <= '1;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], in_n};
        end
    end

    assign pressed_raw = ~sync_p[SYNC_STAGES-1];

    // Debounce: a new level is accepted only after DEBOUNCE_CYCLES steady samples
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (pressed_raw == level) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level <= ~level;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/button_color_select.sv
// Push-button colour selector: short press steps forward, long press steps back.
module button_color_select
    import color_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 12000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_n,
    output logic       RGB_R,
    output logic       RGB_G,
    output logic       RGB_B,
    output logic [2:0] color_idx,
    output logic       short_pulse,
    output logic       long_pulse
);

    localparam int HOLD_W        = $clog2(LONG_CYCLES);
    localparam int SETTLE_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
    localparam int SETTLE_W      = $clog2(SETTLE_CYCLES + 1);
    localparam color_idx_t LAST_IDX = color_idx_t'(NUM_COLORS - 1);

    function automatic color_idx_t idx_fwd(input color_idx_t i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    function automatic color_idx_t idx_back(input color_idx_t i);
        return (i == '0) ? LAST_IDX : i - 1'b1;
    endfunction

    function automatic logic [2:0] rgb_of(input color_idx_t i);
        return (i <= LAST_IDX) ? COLOR_RGB_N[i] : 3'b111;
    endfunction

    logic                btn_db;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                settle_done;
    logic                armed;
    press_state_t        state;
    press_state_t        state_nxt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                hold_done;
    logic [2:0]          rgb_n;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .in_n (btn_n),
        .level(btn_db)
    );

    // A button held through reset reaches btn_db before the settle window ends,
    // so it stays unarmed until a release is seen; a fresh press always arrives later.
    assign settle_done = (settle_cnt == SETTLE_W'(SETTLE_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else begin
            if (!settle_done) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (settle_done && !btn_db) begin
                armed <= 1'b1;
            end
        end
    end

    assign hold_done = (hold_cnt == HOLD_W'(LONG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            hold_cnt <= '0;
        end else if (state == HELD && !hold_done) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (btn_db && armed) state_nxt = HELD;
            HELD: begin
                if (!btn_db) begin
                    state_nxt = IDLE;
                end else if (hold_done) begin
                    state_nxt = LONG_DONE;
                end
            end
            LONG_DONE: if (!btn_db) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Release takes priority over the long threshold in the same cycle
    always_comb begin
        short_pulse = 1'b0;
        long_pulse  = 1'b0;
        if (state == HELD) begin
            if (!btn_db) begin
                short_pulse = 1'b1;
            end else if (hold_done) begin
                long_pulse = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || color_idx > LAST_IDX) begin
            color_idx <= '0;
        end else if (short_pulse) begin
            color_idx <= idx_fwd(color_idx);
        end else if (long_pulse) begin
            color_idx <= idx_back(color_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_n <= COLOR_RGB_N[0];
        end else begin
            rgb_n <= rgb_of(color_idx);
        end
    end

    assign {RGB_R, RGB_G, RGB_B} = rgb_n;

endmodule

// File: tb/tb_button_color_select.sv
// Directed bench for button_color_select with short debounce/long-press thresholds.
module tb_button_color_select;

    localparam int DB = 8;
    localparam int LC = 40;
    localparam int SS = 2;
    localparam int LONG_AT = SS + DB + LC;
    localparam int NV = 14;

    typedef struct {
        int low;
        int high;
        int exp_short;
        int exp_long;
        int exp_idx;
        int exp_long_at;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_n;
    logic       RGB_R, RGB_G, RGB_B;
    logic [2:0] color_idx;
    logic       short_pulse, long_pulse;
    logic [2:0] rgb;

    int checks = 0;
    int failures = 0;
    int n_short, n_long, cyc_n, first_long;
    logic [2:0] prev_idx = 3'd0;
    logic [2:0] pat [0:5];
    vec_t vecs [0:NV-1];

    assign rgb = {RGB_R, RGB_G, RGB_B};

    always #5 clk = ~clk;

    button_color_select #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LC),
        .SYNC_STAGES    (SS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_n      (btn_n),
        .RGB_R      (RGB_R),
        .RGB_G      (RGB_G),
        .RGB_B      (RGB_B),
        .color_idx  (color_idx),
        .short_pulse(short_pulse),
        .long_pulse (long_pulse)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_counts();
        n_short    = 0;
        n_long     = 0;
        cyc_n      = 0;
        first_long = -1;
    endtask

    // One clock; outputs sampled on the falling edge
    task automatic cyc();
        logic r;
        r = reset;
        @(negedge clk);
        cyc_n++;
        if (short_pulse === 1'b1) n_short++;
        if (long_pulse === 1'b1) begin
            n_long++;
            if (first_long < 0) first_long = cyc_n;
        end
        if (r) begin
            check("reset_idx", 32'(color_idx), 32'd0);
            check("reset_rgb", 32'(rgb), 32'b011);
            check("reset_pulses", 32'({short_pulse, long_pulse}), 32'd0);
        end else begin
            check("rgb_lag", 32'(rgb), 32'(pat[prev_idx]));
        end
        prev_idx = color_idx;
    endtask

    task automatic press(input int low, input int high);
        btn_n = 1'b0;
        repeat (low) cyc();
        btn_n = 1'b1;
        repeat (high) cyc();
    endtask

    task automatic check_end(input string name, input int es, input int el, input int ei);
        check({name, "_short"}, 32'(n_short), 32'(es));
        check({name, "_long"}, 32'(n_long), 32'(el));
        check({name, "_idx"}, 32'(color_idx), 32'(ei));
        check({name, "_rgb"}, 32'(rgb), 32'(pat[ei]));
    endtask

    initial begin
        pat[0] = 3'b011; pat[1] = 3'b001; pat[2] = 3'b101;
        pat[3] = 3'b100; pat[4] = 3'b110; pat[5] = 3'b010;

        //          low high  s  l  idx long_at
        vecs[0]  = '{20,  30, 1, 0, 1, -1};
        vecs[1]  = '{100, 30, 0, 1, 0, LONG_AT};
        vecs[2]  = '{100, 30, 0, 1, 5, LONG_AT};
        vecs[3]  = '{20,  30, 1, 0, 0, -1};
        vecs[4]  = '{10,  30, 1, 0, 1, -1};
        vecs[5]  = '{15,  30, 1, 0, 2, -1};
        vecs[6]  = '{25,  30, 1, 0, 3, -1};
        vecs[7]  = '{30,  30, 1, 0, 4, -1};
        vecs[8]  = '{39,  30, 1, 0, 5, -1};
        vecs[9]  = '{12,  30, 1, 0, 0, -1};
        vecs[10] = '{DB-1, 30, 0, 0, 0, -1};
        vecs[11] = '{DB,  30, 1, 0, 1, -1};
        vecs[12] = '{LC,  30, 1, 0, 2, -1};
        vecs[13] = '{LC+1, 30, 0, 1, 1, LONG_AT};

        // Reset with the button held: no press until released and pressed again
        reset = 1'b1;
        btn_n = 1'b0;
        clear_counts();
        repeat (3) cyc();
        reset = 1'b0;
        clear_counts();
        repeat (60) cyc();
        btn_n = 1'b1;
        repeat (30) cyc();
        check_end("held_reset", 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            clear_counts();
            press(vecs[i].low, vecs[i].high);
            check_end($sformatf("vec%0d", i), vecs[i].exp_short, vecs[i].exp_long, vecs[i].exp_idx);
            if (vecs[i].exp_long_at >= 0)
                check($sformatf("vec%0d_long_at", i), 32'(first_long), 32'(vecs[i].exp_long_at));
        end

        // Bouncing input never holds long enough to be accepted
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (3) cyc();
        end
        btn_n = 1'b1;
        repeat (30) cyc();
        check_end("bounce", 0, 0, 1);

        // Reset while HELD: the later release produces nothing
        clear_counts();
        btn_n = 1'b0;
        repeat (20) cyc();
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        repeat (60) cyc();
        btn_n = 1'b1;
        repeat (30) cyc();
        check_end("reset_held", 0, 0, 0);

        clear_counts();
        press(20, 30);
        check_end("after_reset_press", 1, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
